// File: rtl/pinca_pkg.sv
// Shared decode constants: opcodes, funct codes, ALU op codes, PC-source types
// and the control bundle passed from decode_ctrl to the decode stage.
package pinca_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;

    localparam logic [1:0] PCT_IMD   = 2'b00;
    localparam logic [1:0] PCT_REGA  = 2'b01;
    localparam logic [1:0] PCT_INDEX = 2'b10;
    localparam logic [1:0] PCT_EXC   = 2'b11;

    // How the redirect condition is formed from the two operands.
    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_EQ     = 2'b01,
        BR_NE     = 2'b10,
        BR_ALWAYS = 2'b11
    } br_kind_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       writereg;
        logic [4:0] regdest;
        br_kind_t   br;
        logic [1:0] pctype;
        logic       illegal;
    } dec_ctrl_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_ctrl.sv
// Purely combinational instruction decoder: opcode/funct/register fields
// to ID/EX control bundle, redirect kind and PC-source type.
module decode_ctrl
    import pinca_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    input  logic [4:0] rd,
    input  logic       is_nop,
    output dec_ctrl_t  ctl
);

    logic [4:0] dest;

    always_comb begin
        ctl  = '0;
        dest = 5'd0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: begin ctl.aluop = ALU_ADD; dest = rd; end
                    FN_SUB: begin ctl.aluop = ALU_SUB; dest = rd; end
                    FN_AND: begin ctl.aluop = ALU_AND; dest = rd; end
                    FN_OR:  begin ctl.aluop = ALU_OR;  dest = rd; end
                    FN_SLT: begin ctl.aluop = ALU_SLT; dest = rd; end
                    FN_JR: begin
                        ctl.br     = BR_ALWAYS;
                        ctl.pctype = PCT_REGA;
                    end
                    // The all-zero bubble is a legal NOP, not an illegal funct.
                    default: ctl.illegal = !is_nop;
                endcase
            end
            OP_ADDI: begin
                ctl.aluop  = ALU_ADD;
                ctl.alusrc = 1'b1;
                dest       = rt;
            end
            OP_LW: begin
                ctl.aluop   = ALU_ADD;
                ctl.alusrc  = 1'b1;
                ctl.memread = 1'b1;
                dest        = rt;
            end
            OP_SW: begin
                ctl.aluop    = ALU_ADD;
                ctl.alusrc   = 1'b1;
                ctl.memwrite = 1'b1;
            end
            OP_BEQ: begin
                ctl.br     = BR_EQ;
                ctl.pctype = PCT_IMD;
            end
            OP_BNE: begin
                ctl.br     = BR_NE;
                ctl.pctype = PCT_IMD;
            end
            OP_J: begin
                ctl.br     = BR_ALWAYS;
                ctl.pctype = PCT_INDEX;
            end
            default: ctl.illegal = 1'b1;
        endcase

        if (ctl.illegal) begin
            ctl.pctype = PCT_EXC;
        end
        ctl.regdest  = dest;
        ctl.writereg = (dest != 5'd0);
    end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: register reads, branch/jump resolution, wrong-path
// squash FSM and the ID/EX register. Optional macro: DECODE_EXCEPTION_EN.
module decode_stage
    import pinca_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'd64,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] if_id_instruc,
    input  logic [31:0] if_id_nextpc,
    input  logic        ex_if_stall,
    output logic [4:0]  id_reg_addra,
    output logic [4:0]  id_reg_addrb,
    input  logic [31:0] reg_id_dataa,
    input  logic [31:0] reg_id_datab,
    output logic        id_if_selpcsource,
    output logic [1:0]  id_if_selpctype,
    output logic [31:0] id_if_pcimd2ext,
    output logic [31:0] id_if_rega,
    output logic [31:0] id_if_pcindex,
    output logic [31:0] id_ex_rega,
    output logic [31:0] id_ex_regb,
    output logic [31:0] id_ex_imedext,
    output logic [4:0]  id_ex_regdest,
    output logic [2:0]  id_ex_aluop,
    output logic        id_ex_alusrc,
    output logic        id_ex_memread,
    output logic        id_ex_memwrite,
    output logic        id_ex_writereg,
    output logic        dbg_state
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    logic [0:0]  state;
    logic [0:0]  state_next;
    dec_ctrl_t   ctl;
    logic [31:0] imm_ext;
    logic        redirect_cond;
    logic        exc_redirect;
    logic        redirect;
    logic        load_bubble;
    logic        unused_params;

    // EXC_VECTOR is applied by Fetch; kept here so both stages share one value.
    assign unused_params = ^EXC_VECTOR;

    decode_ctrl u_ctrl (
        .opcode (if_id_instruc[31:26]),
        .funct  (if_id_instruc[5:0]),
        .rt     (if_id_instruc[20:16]),
        .rd     (if_id_instruc[15:11]),
        .is_nop (if_id_instruc == NOP_INSTR),
        .ctl    (ctl)
    );

    assign id_reg_addra    = if_id_instruc[25:21];
    assign id_reg_addrb    = if_id_instruc[20:16];
    assign imm_ext         = sext16(if_id_instruc[15:0]);
    assign id_if_pcimd2ext = if_id_nextpc + (imm_ext << 2);
    assign id_if_pcindex   = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};
    assign id_if_rega      = reg_id_dataa;

`ifdef DECODE_EXCEPTION_EN
    assign exc_redirect = ctl.illegal;
`else
    assign exc_redirect = 1'b0;
`endif

    always_comb begin
        redirect_cond = exc_redirect;
        case (ctl.br)
            BR_EQ:     redirect_cond = (reg_id_dataa == reg_id_datab);
            BR_NE:     redirect_cond = (reg_id_dataa != reg_id_datab);
            BR_ALWAYS: redirect_cond = 1'b1;
            default:   ;
        endcase
    end

    // A stall always wins over a redirect; the redirect is re-evaluated once it drops.
    assign redirect          = (state == ST_RUN) && !ex_if_stall && redirect_cond;
    assign id_if_selpcsource = redirect;
    assign id_if_selpctype   = redirect ? ctl.pctype : PCT_IMD;

    always_comb begin
        state_next = state;
        if (!ex_if_stall) begin
            case (state)
                ST_RUN:    state_next = redirect ? ST_SQUASH : ST_RUN;
                ST_SQUASH: state_next = ST_RUN;
                default:   state_next = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    assign dbg_state   = state;
    assign load_bubble = (state == ST_SQUASH) || exc_redirect;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            id_ex_rega     <= 32'd0;
            id_ex_regb     <= 32'd0;
            id_ex_imedext  <= 32'd0;
            id_ex_regdest  <= 5'd0;
            id_ex_aluop    <= 3'd0;
            id_ex_alusrc   <= 1'b0;
            id_ex_memread  <= 1'b0;
            id_ex_memwrite <= 1'b0;
            id_ex_writereg <= 1'b0;
        end else if (!ex_if_stall) begin
            if (load_bubble) begin
                id_ex_rega     <= 32'd0;
                id_ex_regb     <= 32'd0;
                id_ex_imedext  <= 32'd0;
                id_ex_regdest  <= 5'd0;
                id_ex_aluop    <= 3'd0;
                id_ex_alusrc   <= 1'b0;
                id_ex_memread  <= 1'b0;
                id_ex_memwrite <= 1'b0;
                id_ex_writereg <= 1'b0;
            end else begin
                id_ex_rega     <= reg_id_dataa;
                id_ex_regb     <= reg_id_datab;
                id_ex_imedext  <= imm_ext;
                id_ex_regdest  <= ctl.regdest;
                id_ex_aluop    <= ctl.aluop;
                id_ex_alusrc   <= ctl.alusrc;
                id_ex_memread  <= ctl.memread;
                id_ex_memwrite <= ctl.memwrite;
                id_ex_writereg <= ctl.writereg;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table of single-instruction vectors
// plus hand-written redirect/squash/stall/reset sequences.
module tb_decode_stage;

    localparam logic ST_RUN    = 1'b0;
    localparam logic ST_SQUASH = 1'b1;

    logic        clock;
    logic        reset;
    logic [31:0] if_id_instruc;
    logic [31:0] if_id_nextpc;
    logic        ex_if_stall;
    logic [4:0]  id_reg_addra;
    logic [4:0]  id_reg_addrb;
    logic [31:0] reg_id_dataa;
    logic [31:0] reg_id_datab;
    logic        id_if_selpcsource;
    logic [1:0]  id_if_selpctype;
    logic [31:0] id_if_pcimd2ext;
    logic [31:0] id_if_rega;
    logic [31:0] id_if_pcindex;
    logic [31:0] id_ex_rega;
    logic [31:0] id_ex_regb;
    logic [31:0] id_ex_imedext;
    logic [4:0]  id_ex_regdest;
    logic [2:0]  id_ex_aluop;
    logic        id_ex_alusrc;
    logic        id_ex_memread;
    logic        id_ex_memwrite;
    logic        id_ex_writereg;
    logic        dbg_state;

    int checks = 0;
    int errors = 0;
    logic [107:0] exp_q[$];
    logic [107:0] act_idex;

    decode_stage dut (
        .clock             (clock),
        .reset             (reset),
        .if_id_instruc     (if_id_instruc),
        .if_id_nextpc      (if_id_nextpc),
        .ex_if_stall       (ex_if_stall),
        .id_reg_addra      (id_reg_addra),
        .id_reg_addrb      (id_reg_addrb),
        .reg_id_dataa      (reg_id_dataa),
        .reg_id_datab      (reg_id_datab),
        .id_if_selpcsource (id_if_selpcsource),
        .id_if_selpctype   (id_if_selpctype),
        .id_if_pcimd2ext   (id_if_pcimd2ext),
        .id_if_rega        (id_if_rega),
        .id_if_pcindex     (id_if_pcindex),
        .id_ex_rega        (id_ex_rega),
        .id_ex_regb        (id_ex_regb),
        .id_ex_imedext     (id_ex_imedext),
        .id_ex_regdest     (id_ex_regdest),
        .id_ex_aluop       (id_ex_aluop),
        .id_ex_alusrc      (id_ex_alusrc),
        .id_ex_memread     (id_ex_memread),
        .id_ex_memwrite    (id_ex_memwrite),
        .id_ex_writereg    (id_ex_writereg),
        .dbg_state         (dbg_state)
    );

    assign act_idex = {id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_regdest, id_ex_aluop,
                       id_ex_alusrc, id_ex_memread, id_ex_memwrite, id_ex_writereg};

    // Clock and watchdog
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0]  instr;
        logic [31:0]  nextpc;
        logic [31:0]  a;
        logic [31:0]  b;
        logic [31:0]  pcimd;
        logic [107:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [107:0] mk(input logic [31:0] ra, input logic [31:0] rb,
                                        input logic [31:0] imm, input logic [4:0] rd,
                                        input logic [2:0] alu, input logic src,
                                        input logic mr, input logic mw, input logic wr);
        return {ra, rb, imm, rd, alu, src, mr, mw, wr};
    endfunction

    task automatic chk(input string name, input logic [107:0] act, input logic [107:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input logic stall);
        if_id_instruc = instr;
        if_id_nextpc  = pc;
        reg_id_dataa  = a;
        reg_id_datab  = b;
        ex_if_stall   = stall;
        #1;
    endtask

    task automatic chk_redirect(input string name, input logic sel, input logic [1:0] pct);
        chk({name, "_selpcsource"}, 108'(id_if_selpcsource), 108'(sel));
        chk({name, "_selpctype"}, 108'(id_if_selpctype), 108'(pct));
    endtask

    // Push the expected ID/EX contents, clock once, then pop and compare.
    task automatic cycle(input string name, input logic [107:0] exp, input logic exp_state);
        logic [107:0] want;
        exp_q.push_back(exp);
        @(posedge clock);
        #1;
        want = exp_q.pop_front();
        chk({name, "_idex"}, act_idex, want);
        chk({name, "_state"}, 108'(dbg_state), 108'(exp_state));
    endtask

    localparam logic [31:0] I_ADD = 32'h0022_1820;
    localparam logic [31:0] I_BEQ = 32'h1022_0004;

    initial begin
        logic [107:0] add_exp;
        logic [107:0] beq_exp;
        logic [31:0]  instr;

        add_exp = mk(32'd5, 32'd7, 32'h1820, 5'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
        beq_exp = mk(32'd9, 32'd9, 32'd4, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);

        vecs[0]  = '{32'h0022_1820, 32'h0, 32'd5, 32'd7, 32'h0000_6080,
                     mk(32'd5, 32'd7, 32'h1820, 5'd3, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1)};
        vecs[1]  = '{32'h2005_FFFF, 32'h0, 32'd0, 32'h11, 32'hFFFF_FFFC,
                     mk(32'd0, 32'h11, 32'hFFFF_FFFF, 5'd5, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1)};
        vecs[2]  = '{32'h0022_2022, 32'h0, 32'd10, 32'd3, 32'h0000_8088,
                     mk(32'd10, 32'd3, 32'h2022, 5'd4, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1)};
        vecs[3]  = '{32'h0022_3024, 32'h0, 32'hF0, 32'h3C, 32'h0000_C090,
                     mk(32'hF0, 32'h3C, 32'h3024, 5'd6, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1)};
        vecs[4]  = '{32'h0022_3825, 32'h0, 32'hF0, 32'h3C, 32'h0000_E094,
                     mk(32'hF0, 32'h3C, 32'h3825, 5'd7, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1)};
        vecs[5]  = '{32'h0022_402A, 32'h0, 32'd1, 32'd2, 32'h0001_00A8,
                     mk(32'd1, 32'd2, 32'h402A, 5'd8, 3'b100, 1'b0, 1'b0, 1'b0, 1'b1)};
        vecs[6]  = '{32'h8C29_FFF8, 32'h0, 32'h1000, 32'd0, 32'hFFFF_FFE0,
                     mk(32'h1000, 32'd0, 32'hFFFF_FFF8, 5'd9, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1)};
        vecs[7]  = '{32'hAC29_0004, 32'h0, 32'h1000, 32'h55, 32'h0000_0010,
                     mk(32'h1000, 32'h55, 32'd4, 5'd0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0)};
        vecs[8]  = '{32'h1022_0004, 32'h100, 32'd1, 32'd2, 32'h0000_0110,
                     mk(32'd1, 32'd2, 32'd4, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[9]  = '{32'h1422_0004, 32'h200, 32'd3, 32'd3, 32'h0000_0210,
                     mk(32'd3, 32'd3, 32'd4, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[10] = '{32'h0022_0020, 32'h0, 32'd1, 32'd1, 32'h0000_0080,
                     mk(32'd1, 32'd1, 32'h20, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0)};
        vecs[11] = '{32'h0000_0000, 32'h0, 32'h22, 32'h33, 32'h0000_0000,
                     mk(32'h22, 32'h33, 32'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0)};

        // Reset
        reset = 1'b1;
        drive(32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        #11;
        chk("reset_idex", act_idex, 108'd0);
        chk("reset_state", 108'(dbg_state), 108'(ST_RUN));
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Table vectors: none of these redirect
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].instr, vecs[i].nextpc, vecs[i].a, vecs[i].b, 1'b0);
            instr = vecs[i].instr;
            chk($sformatf("v%0d_addra", i), 108'(id_reg_addra), 108'(instr[25:21]));
            chk($sformatf("v%0d_addrb", i), 108'(id_reg_addrb), 108'(instr[20:16]));
            chk($sformatf("v%0d_pcimd2ext", i), 108'(id_if_pcimd2ext), 108'(vecs[i].pcimd));
            chk_redirect($sformatf("v%0d", i), 1'b0, 2'b00);
            cycle($sformatf("v%0d", i), vecs[i].exp, ST_RUN);
        end

        // Taken BEQ, then a second taken BEQ on the wrong path is squashed
        drive(I_BEQ, 32'h100, 32'd9, 32'd9, 1'b0);
        chk_redirect("beq_taken", 1'b1, 2'b00);
        chk("beq_pcimd2ext", 108'(id_if_pcimd2ext), 108'(32'h110));
        cycle("beq_taken", beq_exp, ST_SQUASH);
        drive(I_BEQ, 32'h104, 32'd9, 32'd9, 1'b0);
        chk_redirect("beq_wrongpath", 1'b0, 2'b00);
        cycle("beq_bubble", 108'd0, ST_RUN);

        // Stall beats a redirect in RUN
        drive(I_ADD, 32'h0, 32'd5, 32'd7, 1'b0);
        cycle("pre_stall_add", add_exp, ST_RUN);
        drive(I_BEQ, 32'h100, 32'd9, 32'd9, 1'b1);
        chk_redirect("beq_stalled", 1'b0, 2'b00);
        cycle("beq_stalled", add_exp, ST_RUN);
        drive(I_BEQ, 32'h100, 32'd9, 32'd9, 1'b0);
        chk_redirect("beq_unstalled", 1'b1, 2'b00);
        cycle("beq_unstalled", beq_exp, ST_SQUASH);
        drive(I_ADD, 32'h0, 32'd5, 32'd7, 1'b0);
        cycle("beq_unstalled_bubble", 108'd0, ST_RUN);

        // J, then a 3-cycle stall inside SQUASH
        drive(32'h0800_0010, 32'h1000_0004, 32'h12, 32'h34, 1'b0);
        chk_redirect("j_taken", 1'b1, 2'b10);
        chk("j_pcindex", 108'(id_if_pcindex), 108'(32'h1000_0040));
        cycle("j_taken", mk(32'h12, 32'h34, 32'h10, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0),
              ST_SQUASH);
        for (int k = 0; k < 3; k++) begin
            drive(I_ADD, 32'h0, 32'd5, 32'd7, 1'b1);
            chk_redirect($sformatf("j_stall%0d", k), 1'b0, 2'b00);
            cycle($sformatf("j_stall%0d", k),
                  mk(32'h12, 32'h34, 32'h10, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0), ST_SQUASH);
        end
        drive(I_ADD, 32'h0, 32'd5, 32'd7, 1'b0);
        chk_redirect("j_release", 1'b0, 2'b00);
        cycle("j_bubble", 108'd0, ST_RUN);
        cycle("j_after_add", add_exp, ST_RUN);

        // JR takes the rs operand as target
        drive(32'h0020_0008, 32'h0, 32'h400, 32'h9, 1'b0);
        chk_redirect("jr_taken", 1'b1, 2'b01);
        chk("jr_rega", 108'(id_if_rega), 108'(32'h400));
        cycle("jr_taken", mk(32'h400, 32'h9, 32'h8, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0),
              ST_SQUASH);
        drive(I_ADD, 32'h0, 32'd5, 32'd7, 1'b0);
        cycle("jr_bubble", 108'd0, ST_RUN);

        // Illegal opcode 0x3F
        drive(32'hFC00_0000, 32'h0, 32'h66, 32'h77, 1'b0);
`ifdef DECODE_EXCEPTION_EN
        chk_redirect("illegal", 1'b1, 2'b11);
        cycle("illegal", 108'd0, ST_SQUASH);
        drive(I_ADD, 32'h0, 32'd5, 32'd7, 1'b0);
        cycle("illegal_bubble", 108'd0, ST_RUN);
`else
        chk_redirect("illegal", 1'b0, 2'b00);
        cycle("illegal", mk(32'h66, 32'h77, 32'd0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0),
              ST_RUN);
`endif

        // Asynchronous reset in the middle of SQUASH
        drive(I_ADD, 32'h0, 32'd5, 32'd7, 1'b0);
        cycle("pre_reset_add", add_exp, ST_RUN);
        drive(I_BEQ, 32'h100, 32'd9, 32'd9, 1'b0);
        cycle("pre_reset_beq", beq_exp, ST_SQUASH);
        #2;
        reset = 1'b1;
        #1;
        chk("midreset_idex", act_idex, 108'd0);
        chk("midreset_state", 108'(dbg_state), 108'(ST_RUN));
        #1;
        reset = 1'b0;
        drive(I_BEQ, 32'h100, 32'd9, 32'd9, 1'b0);
        chk_redirect("post_reset_beq", 1'b1, 2'b00);
        cycle("post_reset_beq", beq_exp, ST_SQUASH);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
